// File: rtl/core_pkg.sv
// Shared core types: register address type and hazard controller state encoding.
package core_pkg;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MC_WAIT  = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_e;

    // True when the ID instruction reads the register a load in EX is about to write.
    // x0 is never a real destination, so a load to x0 never causes a bubble.
    function automatic logic load_use_hit(
        input reg_addr_t rs1,
        input reg_addr_t rs2,
        input logic      uses_rs1,
        input logic      uses_rs2,
        input logic      ex_is_load,
        input reg_addr_t ex_rd
    );
        logic hit;
        hit = 1'b0;
        if (ex_is_load && (ex_rd != 5'd0)) begin
            hit = (uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd));
        end
        return hit;
    endfunction

endpackage

// File: rtl/hazard_controller.sv
// Pipeline sequencing block: owns every stall and flush decision of the 5-stage core,
// tracks multi-cycle unit and data-memory waits, and counts stalled cycles.
module hazard_controller #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1_addr,
    input  logic [4:0]           id_rs2_addr,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_rd_addr,
    input  logic                 ex_mc_op,
    input  logic                 mc_done,
    input  logic                 mem_req,
    input  logic                 dmem_ready,
    input  logic                 ex_branch_taken,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 stall_mem,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic                 flush_mem,
    output logic                 mc_start,
    output logic                 mc_error,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_cycles
);
    import core_pkg::*;

    localparam int TO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0]      TO_LIMIT = TO_W'(MC_TIMEOUT);
    localparam logic [TO_W-1:0]      TO_ONE   = TO_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    hz_state_e           state;
    hz_state_e           state_next;
    logic [TO_W-1:0]     timeout_cnt;
    logic                load_use;
    logic                any_stall;

    assign load_use  = load_use_hit(id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
                                    ex_mem_read, ex_rd_addr);
    assign any_stall = stall_if | stall_id | stall_ex | stall_mem;
    assign state_o   = state;

    // State register; reset always lands in RUN so no start pulse can be re-issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and stall/flush decode; everything is forced quiet while reset is held.
    always_comb begin
        state_next = state;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        stall_mem  = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        flush_mem  = 1'b0;
        mc_start   = 1'b0;
        if (!rst) begin
            case (state)
                HZ_MC_WAIT: begin
                    if (mc_done) begin
                        state_next = HZ_RUN;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_next = HZ_RUN;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                    end
                end
                default: begin
                    state_next = HZ_RUN;
                    if (mem_req && !dmem_ready) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        stall_mem  = 1'b1;
                        state_next = HZ_MEM_WAIT;
                    end else if (ex_mc_op) begin
                        mc_start   = 1'b1;
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        flush_mem  = 1'b1;
                        state_next = HZ_MC_WAIT;
                    end else if (ex_branch_taken) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
            endcase
        end
    end

    // Multi-cycle watchdog: counts waiting cycles and latches a sticky error at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt <= '0;
            mc_error    <= 1'b0;
        end else if ((state == HZ_MC_WAIT) && !mc_done) begin
            if ((MC_TIMEOUT != 0) && (timeout_cnt != TO_LIMIT)) begin
                timeout_cnt <= timeout_cnt + TO_ONE;
            end
            if ((MC_TIMEOUT != 0) && (timeout_cnt == (TO_LIMIT - TO_ONE))) begin
                mc_error <= 1'b1;
            end
        end else begin
            timeout_cnt <= '0;
        end
    end

    // Saturating count of cycles in which any pipeline stage was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (any_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

endmodule
